// File: rtl/key_beep_sched_if.sv
`default_nettype none
// ============================================================================
// key_beep_sched_if : key input / buzzer output bundle of key_beep_sched
// Rev 1.0
// ============================================================================
interface key_beep_sched_if;
  logic key_filtered;
  logic beep;
  logic busy;
  logic short_evt;
  logic long_evt;

  // master: key source / buzzer consumer; slave: the sequencer itself
  modport master (output key_filtered, input beep, busy, short_evt, long_evt);
  modport slave  (input key_filtered, output beep, busy, short_evt, long_evt);
endinterface
`default_nettype wire

// File: rtl/key_beep_sched.sv
`default_nettype none
// ============================================================================
// key_beep_sched : classifies key presses and plays one (short) or two (long)
// beeps. Define LONG_PRESS_EN to enable hold timing and long-press patterns.
// Rev 1.0
// ============================================================================
module key_beep_sched #(
  parameter int TONE_HALF  = 25000,
  parameter int BEEP_LEN   = 5000000,
  parameter int GAP_LEN    = 5000000,
  parameter int LONG_PRESS = 50000000
) (
  input logic             sys_clk,
  input logic             sys_rst,
  key_beep_sched_if.slave kb
);
  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_PRESSED = 2'd1;
  localparam logic [1:0] S_BEEP    = 2'd2;
  localparam logic [1:0] S_GAP     = 2'd3;

  localparam logic [25:0] C_TONE_LAST = 26'(TONE_HALF - 1);
  localparam logic [25:0] C_BEEP_LAST = 26'(BEEP_LEN - 1);
  localparam logic [25:0] C_GAP_LAST  = 26'(GAP_LEN - 1);

  logic [1:0]  state_q, state_d;
  logic        key_q;
  logic [25:0] tone_cnt_q, tone_cnt_d;
  logic        tone_q, tone_d;
  logic [25:0] dur_q, dur_d;
  logic [1:0]  beeps_left_q, beeps_left_d;
  logic        beep_q, beep_d;
  logic        busy_q, busy_d;
  logic        short_q, short_d;

  logic w_press_edge;
  logic w_release;
  logic w_beep_end;
  logic w_gap_end;
  logic w_is_long;

  assign w_press_edge = key_q & ~kb.key_filtered;
  assign w_release    = (state_q == S_PRESSED) & kb.key_filtered;
  assign w_beep_end   = (state_q == S_BEEP) & (dur_q == C_BEEP_LAST);
  assign w_gap_end    = (state_q == S_GAP) & (dur_q == C_GAP_LAST);

`ifdef LONG_PRESS_EN
  localparam logic [25:0] C_LONG_PRESS = 26'(LONG_PRESS);

  logic [25:0] hold_q, hold_d;
  logic        long_q, long_d;

  // Hold time saturates so an arbitrarily long press never wraps to "short"
  always_comb begin
    hold_d = hold_q;
    if ((state_q == S_IDLE) && w_press_edge) begin
      hold_d = '0;
    end else if ((state_q == S_PRESSED) && !kb.key_filtered && (hold_q < C_LONG_PRESS)) begin
      hold_d = hold_q + 26'd1;
    end
  end

  assign w_is_long = (hold_q >= C_LONG_PRESS);
  assign long_d    = w_release & w_is_long;
  assign kb.long_evt = long_q;

  always_ff @(posedge sys_clk or negedge sys_rst) begin
    if (!sys_rst) begin
      hold_q <= '0;
      long_q <= 1'b0;
    end else begin
      hold_q <= hold_d;
      long_q <= long_d;
    end
  end
`else
  // LONG_PRESS stays in the parameter list for a uniform interface; it folds away here
  assign w_is_long   = 1'b0 & (LONG_PRESS != 0);
  assign kb.long_evt = 1'b0;
`endif

  // State register
  always_ff @(posedge sys_clk or negedge sys_rst) begin
    if (!sys_rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:    if (w_press_edge) state_d = S_PRESSED;
      S_PRESSED: if (kb.key_filtered) state_d = S_BEEP;
      S_BEEP:    if (w_beep_end) state_d = (beeps_left_q == 2'd1) ? S_IDLE : S_GAP;
      S_GAP:     if (w_gap_end) state_d = S_BEEP;
      default:   state_d = S_IDLE;
    endcase
  end

  // Datapath and registered-output next values
  always_comb begin
    beeps_left_d = beeps_left_q;
    if (w_release) begin
      beeps_left_d = w_is_long ? 2'd2 : 2'd1;
    end else if (w_beep_end) begin
      beeps_left_d = beeps_left_q - 2'd1;
    end

    dur_d = '0;
    if (((state_q == S_BEEP) && !w_beep_end) || ((state_q == S_GAP) && !w_gap_end)) begin
      dur_d = dur_q + 26'd1;
    end

    tone_d     = 1'b0;
    tone_cnt_d = '0;
    if (state_d == S_BEEP) begin
      if (state_q != S_BEEP) begin
        tone_d = 1'b1;
      end else if (tone_cnt_q == C_TONE_LAST) begin
        tone_d = ~tone_q;
      end else begin
        tone_d     = tone_q;
        tone_cnt_d = tone_cnt_q + 26'd1;
      end
    end

    beep_d  = tone_d;
    busy_d  = (state_d == S_BEEP) || (state_d == S_GAP);
    short_d = w_release & ~w_is_long;
  end

  always_ff @(posedge sys_clk or negedge sys_rst) begin
    if (!sys_rst) begin
      key_q        <= 1'b1;
      tone_cnt_q   <= '0;
      tone_q       <= 1'b0;
      dur_q        <= '0;
      beeps_left_q <= 2'd0;
      beep_q       <= 1'b0;
      busy_q       <= 1'b0;
      short_q      <= 1'b0;
    end else begin
      key_q        <= kb.key_filtered;
      tone_cnt_q   <= tone_cnt_d;
      tone_q       <= tone_d;
      dur_q        <= dur_d;
      beeps_left_q <= beeps_left_d;
      beep_q       <= beep_d;
      busy_q       <= busy_d;
      short_q      <= short_d;
    end
  end

  assign kb.beep      = beep_q;
  assign kb.busy      = busy_q;
  assign kb.short_evt = short_q;
endmodule
`default_nettype wire

// File: tb/tb_key_beep_sched.sv
`default_nettype none
// ============================================================================
// tb_key_beep_sched : directed stimulus with a cycle-level pattern model
// Rev 1.0
// ============================================================================
module tb_key_beep_sched;
  localparam int TONE_HALF  = 4;
  localparam int BEEP_LEN   = 40;
  localparam int GAP_LEN    = 20;
  localparam int LONG_PRESS = 100;
`ifdef LONG_PRESS_EN
  localparam bit LONG_ON = 1'b1;
`else
  localparam bit LONG_ON = 1'b0;
`endif

  logic sys_clk = 1'b0;
  logic sys_rst = 1'b0;
  key_beep_sched_if kb ();

  key_beep_sched #(
    .TONE_HALF (TONE_HALF),
    .BEEP_LEN  (BEEP_LEN),
    .GAP_LEN   (GAP_LEN),
    .LONG_PRESS(LONG_PRESS)
  ) dut (
    .sys_clk(sys_clk),
    .sys_rst(sys_rst),
    .kb     (kb)
  );

  always #5 sys_clk = ~sys_clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s @%0t: got %0d, expected %0d", name, $time, act, exp);
    end
  endtask

  // Model: a pattern is just a window [m_start, m_end) of cycle indices
  int m_n, m_hold, m_start, m_end;
  bit m_pressed, m_long, m_key_prev;

  always @(posedge sys_clk or negedge sys_rst) begin
    if (!sys_rst) begin
      m_n <= 0; m_hold <= 0; m_start <= -1; m_end <= 0;
      m_pressed <= 1'b0; m_long <= 1'b0; m_key_prev <= 1'b1;
    end else begin
      m_n <= m_n + 1;
      if (m_pressed) begin
        if (kb.key_filtered) begin
          m_long    <= LONG_ON && (m_hold >= LONG_PRESS);
          m_start   <= m_n + 1;
          m_end     <= m_n + 1 + ((LONG_ON && (m_hold >= LONG_PRESS)) ? 2*BEEP_LEN + GAP_LEN : BEEP_LEN);
          m_pressed <= 1'b0;
        end else if (m_hold < LONG_PRESS) begin
          m_hold <= m_hold + 1;
        end
      end else if ((m_n >= m_end) && m_key_prev && !kb.key_filtered) begin
        m_pressed <= 1'b1;
        m_hold    <= 0;
      end
      m_key_prev <= kb.key_filtered;
    end
  end

  function automatic void exp_at(input int n, output bit b, output bit bu, output bit se, output bit le);
    int r;
    b = 0; bu = 0; se = 0; le = 0;
    if ((m_start >= 0) && (n >= m_start) && (n < m_end)) begin
      r  = n - m_start;
      bu = 1;
      se = (r == 0) && !m_long;
      le = (r == 0) && m_long;
      if (r >= BEEP_LEN + GAP_LEN) r = r - BEEP_LEN - GAP_LEN;
      else if (r >= BEEP_LEN) r = -1;
      b = (r >= 0) && (((r / TONE_HALF) % 2) == 0);
    end
  endfunction

  int tot_busy = 0, tot_beep = 0, tot_short = 0, tot_long = 0;

  always @(negedge sys_clk) begin
    bit eb, ebu, ese, ele;
    if (sys_rst) begin
      exp_at(m_n, eb, ebu, ese, ele);
      check("beep",      32'(kb.beep),      32'(eb));
      check("busy",      32'(kb.busy),      32'(ebu));
      check("short_evt", 32'(kb.short_evt), 32'(ese));
      check("long_evt",  32'(kb.long_evt),  32'(ele));
      tot_busy  <= tot_busy  + int'(kb.busy);
      tot_beep  <= tot_beep  + int'(kb.beep);
      tot_short <= tot_short + int'(kb.short_evt);
      tot_long  <= tot_long  + int'(kb.long_evt);
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge sys_clk);
    #1;
  endtask

  task automatic wait_idle(input string tag);
    int guard = 0;
    while (kb.busy && guard < 500) begin
      @(negedge sys_clk);
      guard++;
    end
    check({tag, " idle timeout"}, 32'(guard < 500), 32'd1);
    tick(5);
  endtask

  task automatic check_totals(input string tag, input int b0, input int h0, input int s0, input int l0,
                              input int e_busy, input int e_beep, input int e_short, input int e_long);
    check({tag, " busy cycles"}, 32'(tot_busy - b0),  32'(e_busy));
    check({tag, " beep cycles"}, 32'(tot_beep - h0),  32'(e_beep));
    check({tag, " short count"}, 32'(tot_short - s0), 32'(e_short));
    check({tag, " long count"},  32'(tot_long - l0),  32'(e_long));
  endtask

  task automatic run_press(input string tag, input int hold,
                           input int e_busy, input int e_beep, input int e_short, input int e_long);
    int b0, h0, s0, l0, lat;
    b0 = tot_busy; h0 = tot_beep; s0 = tot_short; l0 = tot_long;
    kb.key_filtered = 1'b0;
    tick(hold);
    kb.key_filtered = 1'b1;
    lat = 0;
    while (!kb.busy && lat < 10) begin
      @(negedge sys_clk);
      lat++;
    end
    check({tag, " latency"}, 32'(lat), 32'd2);
    wait_idle(tag);
    check_totals(tag, b0, h0, s0, l0, e_busy, e_beep, e_short, e_long);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int b0, h0, s0, l0, guard;
    kb.key_filtered = 1'b1;
    sys_rst = 1'b0;
    tick(3);
    check("rst beep",  32'(kb.beep),      32'd0);
    check("rst busy",  32'(kb.busy),      32'd0);
    check("rst short", 32'(kb.short_evt), 32'd0);
    check("rst long",  32'(kb.long_evt),  32'd0);
    sys_rst = 1'b1;

    b0 = tot_busy; h0 = tot_beep; s0 = tot_short; l0 = tot_long;
    tick(50);
    check_totals("idle", b0, h0, s0, l0, 0, 0, 0, 0);

    run_press("short", 30, 40, 20, 1, 0);
    if (LONG_ON) run_press("long", 150, 100, 40, 0, 1);
    else         run_press("long", 150, 40, 20, 1, 0);

    // Second press during BEEP must be ignored
    b0 = tot_busy; h0 = tot_beep; s0 = tot_short; l0 = tot_long;
    kb.key_filtered = 1'b0; tick(30);
    kb.key_filtered = 1'b1; tick(5);
    kb.key_filtered = 1'b0; tick(5);
    kb.key_filtered = 1'b1;
    wait_idle("during beep");
    check_totals("during beep", b0, h0, s0, l0, 40, 20, 1, 0);

    // Key held across the return to IDLE: its release is not a press
    b0 = tot_busy; h0 = tot_beep; s0 = tot_short; l0 = tot_long;
    kb.key_filtered = 1'b0; tick(30);
    kb.key_filtered = 1'b1; tick(10);
    kb.key_filtered = 1'b0; tick(60);
    kb.key_filtered = 1'b1; tick(30);
    check("held busy", 32'(kb.busy), 32'd0);
    check_totals("held", b0, h0, s0, l0, 40, 20, 1, 0);

    // Asynchronous reset in the 20th beep cycle
    kb.key_filtered = 1'b0; tick(30);
    kb.key_filtered = 1'b1;
    guard = 0;
    while (!kb.busy && guard < 10) begin
      @(negedge sys_clk);
      guard++;
    end
    check("rst-mid start", 32'(kb.busy), 32'd1);
    repeat (19) @(negedge sys_clk);
    check("rst-mid beep before", 32'(kb.beep), 32'd1);
    #1 sys_rst = 1'b0;
    #1;
    check("rst-mid beep", 32'(kb.beep), 32'd0);
    check("rst-mid busy", 32'(kb.busy), 32'd0);
    tick(3);
    sys_rst = 1'b1;
    tick(5);
    run_press("after rst", 30, 40, 20, 1, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
`default_nettype wire
